// File: rtl/left_shift_deserializer_ctrl_if.sv
// left_shift_deserializer_ctrl_if
// Groups the serial input stream and the parallel output stream of the
// deserializer controller.
//   s_valid/s_data/s_ready : one-bit serial stream into the controller
//   m_valid/m_data/m_count/m_ready : word stream out of the controller
// Modports:
//   slave  - the controller's view (it sinks bits and sources words)
//   master - the environment's view (it sources bits and sinks words)
interface left_shift_deserializer_ctrl_if #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
);
  logic             s_valid;
  logic             s_data;
  logic             s_ready;
  logic             m_valid;
  logic             m_ready;
  logic [DEPTH-1:0] m_data;
  logic [CW-1:0]    m_count;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_count
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_count
  );
endinterface

// File: rtl/left_shift_deserializer_ctrl.sv
// left_shift_deserializer_ctrl
// Sequences an external left shift register of the same DEPTH as a
// serial-to-parallel deserializer. Bits arrive oldest-first and end up with
// the oldest bit in the MSB; after DEPTH accepted bits the register contents
// are offered as one word until the consumer takes it.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high
//   bus        stream interface (slave modport): serial in, word out
//   flush      (only with LEFT_SHIFT_DESER_FLUSH_EN) emit a partial word
//   sr_enable  shift enable to the register
//   sr_reset   synchronous clear to the register
//   sr_in      serial data to the register
//   sr_out     register contents read back
//   busy       a word is partially filled or waiting to be taken
//
// Optional feature macro: LEFT_SHIFT_DESER_FLUSH_EN
//
// state | meaning
// FILL  | accepting serial bits, bit_cnt holds bits shifted so far
// HOLD  | word presented on m_data, register frozen until handshake
module left_shift_deserializer_ctrl #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  left_shift_deserializer_ctrl_if.slave bus,
`ifdef LEFT_SHIFT_DESER_FLUSH_EN
  input  logic                          flush,
`endif
  output logic                          sr_enable,
  output logic                          sr_reset,
  output logic                          sr_in,
  input  logic [DEPTH-1:0]              sr_out,
  output logic                          busy
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] count_q;
  logic          s_ready_q;
  logic          m_valid_q;

  logic accept;
  logic handshake;
  logic flush_go;

  // Gating with reset keeps both handshakes closed from the very first
  // reset cycle, before the registered flags have been initialised.
  assign bus.s_ready = s_ready_q & ~reset;
  assign bus.m_valid = m_valid_q & ~reset;
  assign bus.m_data  = sr_out;
  assign bus.m_count = reset ? '0 : count_q;

  assign accept    = bus.s_valid & bus.s_ready;
  assign handshake = bus.m_valid & bus.m_ready;

  // An accept in the same cycle wins over flush.
`ifdef LEFT_SHIFT_DESER_FLUSH_EN
  assign flush_go = (state == FILL) & flush & (bit_cnt != '0) & ~accept & ~reset;
`else
  assign flush_go = 1'b0;
`endif

  assign sr_in     = bus.s_data;
  assign sr_enable = accept;
  // Clearing at the handshake edge leaves the register empty for the next
  // word and zero-fills the upper bits of any flushed partial word.
  assign sr_reset  = reset | handshake;

  assign busy = (state == HOLD) | ((state == FILL) & (bit_cnt != '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FILL;
      bit_cnt   <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if (bit_cnt == CW'(DEPTH - 1)) begin
              state     <= HOLD;
              bit_cnt   <= '0;
              count_q   <= CW'(DEPTH);
              s_ready_q <= 1'b0;
              m_valid_q <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end else if (flush_go) begin
            state     <= HOLD;
            count_q   <= bit_cnt;
            bit_cnt   <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            state     <= FILL;
            count_q   <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
